// File: rtl/pipelined_rca_addsub_pkg.sv
// Shared ALU definitions for the pipelined ripple-carry adder/subtractor:
// operation-mode encoding and slice-geometry helpers.
package pipelined_rca_addsub_pkg;

    // Operation select carried on the 'sub' input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Bits handled by each pipeline slice.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    // Legal geometry: at least two result bits, at least one slice and
    // every slice the same width.
    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_rca_addsub_if.sv
// Operand/result bus of the pipelined adder/subtractor.
//
// Handshake: a beat moves on a rising clk edge where valid and ready are both
// 1. The sender keeps valid and its payload stable until that edge. Ready may
// depend combinationally on the receiver's own state but never on valid, so
// no combinational loop forms through the pair.
interface pipelined_rca_addsub_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf, zero
    );

endinterface

// File: rtl/pipelined_rca_addsub_rca_slice.sv
// One combinational ripple-carry slice built from a full-adder chain.
// c_msb_in is the carry entering the slice's top bit; only the most
// significant slice of the pipeline uses it, to form the overflow flag.
module rca_slice #(
    parameter int S = 16
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         ci,
    output logic [S-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [S:0] c;

    // Full-adder chain from bit 0 upward.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < S; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co       = c[S];
    assign c_msb_in = c[S-1];

endmodule

// File: rtl/pipelined_rca_addsub.sv
// WIDTH-bit adder/subtractor whose carry chain is cut into STAGES equal
// slices with a register boundary after each slice. Every stage register
// carries the full-width operands and partial sum, so the operand skew on the
// way in and the result de-skew on the way out fall out of one regular shift
// structure. All stages advance together or hold together; bubbles stay put.
module pipelined_rca_addsub
    import pipelined_rca_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic                  clk,
    input logic                  rst,
    pipelined_rca_addsub_if.slave bus
);

    localparam int S = slice_width(WIDTH, STAGES);
    localparam int L = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_rca_addsub: WIDTH must be >= 2 and a multiple of STAGES");
    end

    logic             advance;
    logic             carry0;
    logic [WIDTH-1:0] b_eff;

    // Stage registers: entry k holds the beat that has passed slice k.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0]            carry_q, carry_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic                         ovf_q, ovf_d;
    logic                         zero_q, zero_d;

    // Inputs seen by each slice: the bus for slice 0, the previous stage
    // register for every later slice.
    logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in;
    logic [STAGES-1:0]            ci_in, v_in;

    logic [STAGES-1:0][S-1:0]     slice_s;
    logic [STAGES-1:0]            slice_co;
    logic [STAGES-1:0]            slice_cm;

    assign advance      = bus.out_ready | ~valid_q[L];
    assign bus.in_ready = advance;

    // Subtraction is a + ~b + 1, so the operand is inverted once on entry
    // and the forced carry replaces c_in.
    assign b_eff  = (bus.sub == MODE_ADD) ? bus.b : ~bus.b;
    assign carry0 = (bus.sub == MODE_SUB) ? 1'b1 : bus.c_in;

    if (STAGES == 1) begin : g_single
        assign a_in   = bus.a;
        assign b_in   = b_eff;
        assign sum_in = '0;
        assign ci_in  = carry0;
        assign v_in   = bus.in_valid;
    end else begin : g_chain
        assign a_in   = {a_q[STAGES-2:0], bus.a};
        assign b_in   = {b_q[STAGES-2:0], b_eff};
        assign sum_in = {sum_q[STAGES-2:0], {WIDTH{1'b0}}};
        assign ci_in  = {carry_q[STAGES-2:0], carry0};
        assign v_in   = {valid_q[STAGES-2:0], bus.in_valid};
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        rca_slice #(.S(S)) u_rca (
            .a        (a_in[k][k*S +: S]),
            .b        (b_in[k][k*S +: S]),
            .ci       (ci_in[k]),
            .s        (slice_s[k]),
            .co       (slice_co[k]),
            .c_msb_in (slice_cm[k])
        );
    end

    // Next stage contents: shift everything one slot and drop each slice's
    // result bits into its own field; flags come from the finished top slice.
    always_comb begin
        valid_d = v_in;
        carry_d = slice_co;
        a_d     = a_in;
        b_d     = b_in;
        sum_d   = sum_in;
        for (int k = 0; k < STAGES; k++) begin
            sum_d[k][k*S +: S] = slice_s[k];
        end
        ovf_d  = slice_cm[L] ^ slice_co[L];
        zero_d = (sum_d[L] == '0);
    end

    // Stage registers: cleared by reset, loaded together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else if (advance) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.out_valid = valid_q[L];
    assign bus.sum       = sum_q[L];
    assign bus.c_out     = carry_q[L];
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // Operand bits below a slice's position are never consumed downstream,
    // and only the top slice's MSB carry feeds a flag; they are gathered here
    // so the intentionally dead bits are collected in one place.
    logic unused_bits;
    assign unused_bits = ^{a_q, b_q, a_in, b_in, slice_cm};

endmodule
